// File: rtl/codec_tdm_if.sv
// Codec TDM serial interface: derives BICK/LRCK from a free-running frame counter,
// shifts four DAC slots out and four ADC slots in per 256-cycle frame.
module codec_tdm_if #(
   parameter int W         = 16,
   parameter int SLOT_BITS = 32
) (
   input  logic         clk_256fs,
   input  logic         rst,
   output logic         bick,
   output logic         lrck,
   output logic         sdout,
   input  logic         sdin,
   input  logic [W-1:0] dac_in0,
   input  logic [W-1:0] dac_in1,
   input  logic [W-1:0] dac_in2,
   input  logic [W-1:0] dac_in3,
   output logic [W-1:0] adc_out0,
   output logic [W-1:0] adc_out1,
   output logic [W-1:0] adc_out2,
   output logic [W-1:0] adc_out3,
   output logic         sample_valid
);

   if (W < 8 || W > 32) begin : g_bad_w
      $error("codec_tdm_if: W must be in 8..32");
   end
   if (SLOT_BITS != 32) begin : g_bad_slot
      $error("codec_tdm_if: SLOT_BITS must be 32");
   end

   localparam logic [5:0] LP_W = 6'(W);

   logic [7:0]   r_cnt;
   logic         r_bick;
   logic         r_lrck;
   logic         r_sdout;
   logic         r_sample_valid;
   logic [W-1:0] r_tx  [4];
   logic [W-1:0] r_rx  [4];
   logic [W-1:0] r_adc [4];
   logic [W-1:0] w_dac [4];

   logic [7:0]   w_cnt_nxt;
   logic         w_wrap;
   logic [5:0]   w_bit_nxt;
   logic [5:0]   w_idx_nxt;
   logic [5:0]   w_bit_cur;
   logic [5:0]   w_idx_cur;
   logic [W-1:0] w_tx_word;
   logic [W-1:0] w_tx_shift;
   logic         w_sd_nxt;
   logic         w_capture;
   logic [W-1:0] w_rx_mask;
   logic [W-1:0] w_rx_upd;

   assign w_dac[0] = dac_in0;
   assign w_dac[1] = dac_in1;
   assign w_dac[2] = dac_in2;
   assign w_dac[3] = dac_in3;

   always_comb begin
      w_cnt_nxt  = r_cnt + 8'd1;
      w_wrap     = (r_cnt == 8'hFF);
      // The pin values are computed for the count the edge is about to enter, so the
      // first bit of a new frame must come straight from dac_in being latched on that edge.
      w_bit_nxt  = {1'b0, w_cnt_nxt[5:1]};
      w_idx_nxt  = LP_W - 6'd1 - w_bit_nxt;
      w_tx_word  = w_wrap ? w_dac[w_cnt_nxt[7:6]] : r_tx[w_cnt_nxt[7:6]];
      w_tx_shift = w_tx_word >> w_idx_nxt;
      w_sd_nxt   = (w_bit_nxt < LP_W) & w_tx_shift[0];
      // Capture on the BICK rising edge, i.e. leaving an even count.
      w_bit_cur  = {1'b0, r_cnt[5:1]};
      w_idx_cur  = LP_W - 6'd1 - w_bit_cur;
      w_capture  = ~r_cnt[0] & (w_bit_cur < LP_W);
      w_rx_mask  = W'(1) << w_idx_cur;
      w_rx_upd   = sdin ? (r_rx[r_cnt[7:6]] | w_rx_mask)
                        : (r_rx[r_cnt[7:6]] & ~w_rx_mask);
   end

   always_ff @(posedge clk_256fs or posedge rst) begin
      if (rst) begin
         r_cnt          <= '0;
         r_bick         <= 1'b0;
         r_lrck         <= 1'b0;
         r_sdout        <= 1'b0;
         r_sample_valid <= 1'b0;
         for (int n = 0; n < 4; n++) begin
            r_tx[n]  <= '0;
            r_rx[n]  <= '0;
            r_adc[n] <= '0;
         end
      end else begin
         r_cnt          <= w_cnt_nxt;
         r_bick         <= w_cnt_nxt[0];
         r_lrck         <= ~w_cnt_nxt[7];
         r_sdout        <= w_sd_nxt;
         r_sample_valid <= w_wrap;
         if (w_wrap) begin
            for (int n = 0; n < 4; n++) begin
               r_tx[n]  <= w_dac[n];
               r_adc[n] <= r_rx[n];
            end
         end
         if (w_capture) begin
            r_rx[r_cnt[7:6]] <= w_rx_upd;
         end
      end
   end

   assign bick         = r_bick;
   assign lrck         = r_lrck;
   assign sdout        = r_sdout;
   assign sample_valid = r_sample_valid;
   assign adc_out0     = r_adc[0];
   assign adc_out1     = r_adc[1];
   assign adc_out2     = r_adc[2];
   assign adc_out3     = r_adc[3];

endmodule
